controle_porta: RTL and testbench

CONTROLE_PORTA -- requirements
Module: controle_porta

---
 rtl/controle_porta.sv | 137 +++++++++++++
 tb/tb_controle_porta.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_porta.sv
// controle_porta: elevator door controller for one floor.
//
// A four-state Moore FSM drives the door motor open, holds the door open for a
// dwell time, and drives it closed again. While closing, an obstruction or a
// new call reopens the door. When a close completes, the cabin is released
// with a one-cycle pulse.
//
// Parameters
//   T_MOV     door travel time in cycles (1..255)
//   T_ABERTA  door dwell time in cycles (1..255)
//
// Ports
//   clock             system clock, rising edge
//   reset             asynchronous reset, active low
//   chamada           level request to open the door
//   capacidade_atual  occupancy count 0..3 (3 = full)
//   sensor_obstaculo  door-path obstruction, active high
//   motor_abrir       drive motor in the open direction
//   motor_fechar      drive motor in the close direction
//   porta_aberta      door fully open
//   alerta_lotacao    door open and cabin full
//   liberado_partida  one-cycle pulse: door closed, cabin may move
module controle_porta #(
    parameter int unsigned T_MOV    = 4,
    parameter int unsigned T_ABERTA = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       chamada,
    input  logic [1:0] capacidade_atual,
    input  logic       sensor_obstaculo,
    output logic       motor_abrir,
    output logic       motor_fechar,
    output logic       porta_aberta,
    output logic       alerta_lotacao,
    output logic       liberado_partida
);

    typedef enum logic [1:0] {
        StFechada,
        StAbrindo,
        StAberta,
        StFechando
    } state_e;

    // Last timer value of each timed state; compared against the full 8 bits.
    localparam logic [7:0] MovLast    = 8'(T_MOV - 1);
    localparam logic [7:0] AbertaLast = 8'(T_ABERTA - 1);

    state_e     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [1:0] cap_prev_q;
    logic       lib_q, lib_d;

    logic [7:0] timer_inc;
    logic       cap_mudou;

    // Saturating increment: the timer never wraps back to zero.
    assign timer_inc = (timer_q == 8'hFF) ? timer_q : timer_q + 8'd1;
    assign cap_mudou = (capacidade_atual != cap_prev_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StFechada;
            timer_q    <= 8'd0;
            cap_prev_q <= 2'd0;
            lib_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            cap_prev_q <= capacidade_atual;
            lib_q      <= lib_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_inc;
        lib_d   = 1'b0;
        unique case (state_q)
            StFechada: begin
                timer_d = 8'd0;
                if (chamada) begin
                    state_d = StAbrindo;
                end
            end
            StAbrindo: begin
                // Calls and obstructions have no effect while opening.
                if (timer_q == MovLast) begin
                    state_d = StAberta;
                    timer_d = 8'd0;
                end
            end
            StAberta: begin
                // A restart in the expiry cycle takes priority over closing.
                if (chamada || cap_mudou) begin
                    timer_d = 8'd0;
                end else if (timer_q == AbertaLast) begin
                    state_d = StFechando;
                    timer_d = 8'd0;
                end
            end
            StFechando: begin
                // Reopen requests win even in the final closing cycle.
                if (sensor_obstaculo || chamada) begin
                    state_d = StAbrindo;
                    timer_d = 8'd0;
                end else if (timer_q == MovLast) begin
                    state_d = StFechada;
                    timer_d = 8'd0;
                    lib_d   = 1'b1;
                end
            end
            default: begin
                state_d = StFechada;
                timer_d = 8'd0;
            end
        endcase
    end

    // Moore decode from the state register only.
    always_comb begin
        motor_abrir  = 1'b0;
        motor_fechar = 1'b0;
        porta_aberta = 1'b0;
        unique case (state_q)
            StAbrindo:  motor_abrir  = 1'b1;
            StAberta:   porta_aberta = 1'b1;
            StFechando: motor_fechar = 1'b1;
            default:    ;
        endcase
    end

    assign alerta_lotacao   = porta_aberta && (capacidade_atual == 2'd3);
    assign liberado_partida = lib_q;

endmodule

// File: tb/tb_controle_porta.sv
// Self-checking bench for controle_porta with default timing (4 / 10).
// Directed scenarios queue per-cycle stimulus and expected outputs; each cycle
// pops one of each, applies the stimulus and compares the outputs.
module tb_controle_porta;

    localparam int unsigned TMov    = 4;
    localparam int unsigned TAberta = 10;

    // Output vector layout: {motor_abrir, motor_fechar, porta_aberta, alerta, liberado}
    localparam logic [4:0] EIdle = 5'b00000;
    localparam logic [4:0] EAbr  = 5'b10000;
    localparam logic [4:0] EFch  = 5'b01000;
    localparam logic [4:0] EAbt  = 5'b00100;
    localparam logic [4:0] EFull = 5'b00110;
    localparam logic [4:0] ELib  = 5'b00001;

    // Stimulus layout: {chamada, sensor_obstaculo, capacidade_atual[1:0]}
    localparam logic [3:0] SNone = 4'b0000;
    localparam logic [3:0] SCall = 4'b1000;
    localparam logic [3:0] SObst = 4'b0100;

    logic       clock;
    logic       reset;
    logic       chamada;
    logic [1:0] capacidade_atual;
    logic       sensor_obstaculo;
    logic       motor_abrir;
    logic       motor_fechar;
    logic       porta_aberta;
    logic       alerta_lotacao;
    logic       liberado_partida;

    int compared   = 0;
    int mismatched = 0;

    logic [3:0] stim_q[$];
    logic [4:0] exp_q[$];

    controle_porta #(
        .T_MOV   (TMov),
        .T_ABERTA(TAberta)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .chamada         (chamada),
        .capacidade_atual(capacidade_atual),
        .sensor_obstaculo(sensor_obstaculo),
        .motor_abrir     (motor_abrir),
        .motor_fechar    (motor_fechar),
        .porta_aberta    (porta_aberta),
        .alerta_lotacao  (alerta_lotacao),
        .liberado_partida(liberado_partida)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [4:0] outs();
        return {motor_abrir, motor_fechar, porta_aberta, alerta_lotacao, liberado_partida};
    endfunction

    task automatic push(input logic [3:0] s, input logic [4:0] e, input int n);
        for (int i = 0; i < n; i++) begin
            stim_q.push_back(s);
            exp_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        reset            = 1'b0;
        chamada          = 1'b0;
        sensor_obstaculo = 1'b0;
        capacidade_atual = 2'd0;
        #1;
        compared++;
        if (outs() !== EIdle) begin
            mismatched++;
            $display("FAIL reset_async: got %b, want %b", outs(), EIdle);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            #1;
            compared++;
            if (outs() !== EIdle) begin
                mismatched++;
                $display("FAIL reset_release cycle %0d: got %b, want %b", c, outs(), EIdle);
            end
        end
    endtask

    task automatic test_basic();
        logic [4:0] e;
        int cyc = 0;
        push(SCall, EIdle, 1);
        push(SNone, EAbr, TMov);
        push(SNone, EAbt, TAberta);
        push(SNone, EFch, TMov);
        push(SNone, ELib, 1);
        push(SNone, EIdle, 2);
        while (exp_q.size() > 0) begin
            @(negedge clock);
            {chamada, sensor_obstaculo, capacidade_atual} = stim_q.pop_front();
            #1;
            e = exp_q.pop_front();
            compared++;
            if (outs() !== e) begin
                mismatched++;
                $display("FAIL basic cycle %0d: got %b, want %b", cyc, outs(), e);
            end
            cyc++;
        end
    endtask

    // Occupancy 0->1 in the 7th open cycle: 7 + 10 = 17 open cycles in total.
    task automatic test_boarding();
        logic [4:0] e;
        int cyc = 0;
        push(SCall, EIdle, 1);
        push(SNone, EAbr, TMov);
        push(SNone, EAbt, 6);
        push(4'b0001, EAbt, 1 + TAberta);
        push(4'b0001, EFch, TMov);
        push(4'b0001, ELib, 1);
        push(SNone, EIdle, 2);
        while (exp_q.size() > 0) begin
            @(negedge clock);
            {chamada, sensor_obstaculo, capacidade_atual} = stim_q.pop_front();
            #1;
            e = exp_q.pop_front();
            compared++;
            if (outs() !== e) begin
                mismatched++;
                $display("FAIL boarding cycle %0d: got %b, want %b", cyc, outs(), e);
            end
            cyc++;
        end
    endtask

    task automatic test_full();
        logic [4:0] e;
        int cyc = 0;
        push(4'b1011, EIdle, 1);
        push(4'b0011, EIdle, 1);
        push(4'b0011, EAbr, TMov - 1);
        push(4'b0011, EFull, TAberta);
        push(4'b0011, EFch, TMov);
        push(4'b0011, ELib, 1);
        push(4'b0011, EIdle, 1);
        push(SNone, EIdle, 1);
        // Second entry above is really the first opening cycle.
        exp_q[1] = EAbr;
        while (exp_q.size() > 0) begin
            @(negedge clock);
            {chamada, sensor_obstaculo, capacidade_atual} = stim_q.pop_front();
            #1;
            e = exp_q.pop_front();
            compared++;
            if (outs() !== e) begin
                mismatched++;
                $display("FAIL full cycle %0d: got %b, want %b", cyc, outs(), e);
            end
            cyc++;
        end
    endtask

    // Obstruction in closing cycle 2, then in the final closing cycle.
    task automatic test_obstruction();
        logic [4:0] e;
        int cyc = 0;
        push(SCall, EIdle, 1);
        push(SNone, EAbr, TMov);
        push(SNone, EAbt, TAberta);
        push(SNone, EFch, 1);
        push(SObst, EFch, 1);
        push(SNone, EAbr, TMov);
        push(SNone, EAbt, TAberta);
        push(SNone, EFch, TMov - 1);
        push(SObst, EFch, 1);
        push(SNone, EAbr, TMov);
        push(SNone, EAbt, TAberta);
        push(SNone, EFch, TMov);
        push(SNone, ELib, 1);
        push(SNone, EIdle, 2);
        while (exp_q.size() > 0) begin
            @(negedge clock);
            {chamada, sensor_obstaculo, capacidade_atual} = stim_q.pop_front();
            #1;
            e = exp_q.pop_front();
            compared++;
            if (outs() !== e) begin
                mismatched++;
                $display("FAIL obstruction cycle %0d: got %b, want %b", cyc, outs(), e);
            end
            cyc++;
        end
    endtask

    // Call in the last dwell cycle restarts the dwell instead of closing.
    task automatic test_expiry_restart();
        logic [4:0] e;
        int cyc = 0;
        push(SCall, EIdle, 1);
        push(SNone, EAbr, TMov);
        push(SNone, EAbt, TAberta - 1);
        push(SCall, EAbt, 1);
        push(SNone, EAbt, TAberta);
        push(SNone, EFch, TMov);
        push(SNone, ELib, 1);
        push(SNone, EIdle, 2);
        while (exp_q.size() > 0) begin
            @(negedge clock);
            {chamada, sensor_obstaculo, capacidade_atual} = stim_q.pop_front();
            #1;
            e = exp_q.pop_front();
            compared++;
            if (outs() !== e) begin
                mismatched++;
                $display("FAIL expiry_restart cycle %0d: got %b, want %b", cyc, outs(), e);
            end
            cyc++;
        end
    endtask

    task automatic test_reset_closing();
        logic [4:0] e;
        int cyc = 0;
        push(SCall, EIdle, 1);
        push(SNone, EAbr, TMov);
        push(SNone, EAbt, TAberta);
        push(SNone, EFch, 3);
        while (exp_q.size() > 0) begin
            @(negedge clock);
            {chamada, sensor_obstaculo, capacidade_atual} = stim_q.pop_front();
            #1;
            e = exp_q.pop_front();
            compared++;
            if (outs() !== e) begin
                mismatched++;
                $display("FAIL reset_closing cycle %0d: got %b, want %b", cyc, outs(), e);
            end
            cyc++;
        end
        // Mid-cycle, away from any clock edge: motor must drop at once.
        #1 reset = 1'b0;
        #1;
        compared++;
        if (outs() !== EIdle) begin
            mismatched++;
            $display("FAIL reset_closing_async: got %b, want %b", outs(), EIdle);
        end
        @(negedge clock);
        #1;
        compared++;
        if (outs() !== EIdle) begin
            mismatched++;
            $display("FAIL reset_closing_held: got %b, want %b", outs(), EIdle);
        end
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            #1;
            compared++;
            if (outs() !== EIdle) begin
                mismatched++;
                $display("FAIL reset_closing_after cycle %0d: got %b, want %b", c, outs(), EIdle);
            end
        end
    endtask

    task automatic test_random();
        logic [4:0] o;
        int run    = 0;
        int pulses = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clock);
            chamada          = ($urandom_range(15) == 0);
            sensor_obstaculo = ($urandom_range(15) == 0);
            if ($urandom_range(7) == 0) capacidade_atual = 2'($urandom_range(3));
            #1;
            o = outs();
            compared++;
            if ($countones(o[4:2]) > 1) begin
                mismatched++;
                $display("FAIL random_mutex cycle %0d: got %b, want at most one of [4:2]", i, o);
            end
            compared++;
            if (alerta_lotacao !== (porta_aberta && (capacidade_atual == 2'd3))) begin
                mismatched++;
                $display("FAIL random_alerta cycle %0d: got %b, want %b", i, alerta_lotacao,
                         porta_aberta && (capacidade_atual == 2'd3));
            end
            if (liberado_partida) begin
                pulses++;
                compared++;
                if (run != TMov) begin
                    mismatched++;
                    $display("FAIL random_close_run cycle %0d: got %0d, want %0d", i, run, TMov);
                end
            end
            run = motor_fechar ? run + 1 : 0;
        end
        compared++;
        if (pulses == 0) begin
            mismatched++;
            $display("FAIL random_pulses: got %0d, want > 0", pulses);
        end
        @(negedge clock);
        chamada          = 1'b0;
        sensor_obstaculo = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boarding();
        test_full();
        test_obstruction();
        test_expiry_restart();
        test_reset_closing();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
